id_ex_reg: RTL
==============

# id_ex_reg

ID/EX pipeline register of the pipelined MIPS core. It captures decode-stage control and operand data on each clock and presents them to the execute stage, where they drive the ALU operands, the alu_control input and the EX/MEM register. It supports hazard-unit stall (hold) and flush (bubble insertion). It also keeps a saturating count of the bubbles it has inserted, for performance debug.

## Interface
- W, 32, datapath width (register data, immediate, PC+4).
- CNT_W, 16, width of the bubble counter.

- clk  in  1  single clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- stall  in  1  hazard unit: hold current contents.
- flush  in  1  hazard/branch unit: load a bubble.
- id_valid  in  1  decode slot holds a real instruction.
- id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg, id_alu_src, id_reg_dst, id_branch  in  1 each  decode control bits.
- id_alu_op  in  2  ALU op class for alu_control (00 add, 01 sub, 10 R-type funct, 11 immediate-logic).
- id_pc_plus4, id_rs_data, id_rt_data, id_imm_ext  in  W each  decode data.
- id_rs, id_rt, id_rd  in  5 each  register specifiers.
- id_funct  in  6  instruction funct field.
- ex_* outputs  out  same widths as id_* counterparts  registered copies (ex_valid, ex_reg_write, …, ex_funct).
- bubble_count  out  CNT_W  number of bubbles inserted since reset, saturating.

## Operation
- Per-edge priority, highest first: reset > flush > stall > load.
- reset: every ex_* output goes to 0, including ex_valid, all control bits, all data and specifier fields. bubble_count goes to 0.
- flush (regardless of stall):
  - ex_valid, ex_reg_write, ex_mem_read, ex_mem_write and ex_branch go to 0.
  - The remaining control bits, ex_alu_op, and all data and specifier fields also go to 0. A flushed slot is an all-zero NOP.
  - bubble_count increments.
- stall (flush=0): all ex_* outputs hold their values. bubble_count holds.
- load (flush=0, stall=0): every ex_* output takes its id_* input.
- Bubble injection on load: if id_valid=0, the load proceeds with the same gating as a flush:
  - ex_valid, ex_reg_write, ex_mem_read, ex_mem_write and ex_branch are forced to 0.
  - Data fields still load.
  - bubble_count increments.
- Gating rule: ex_reg_write, ex_mem_read, ex_mem_write and ex_branch are never 1 while ex_valid=0. Downstream logic relies on this.
- bubble_count saturates at 2^CNT_W−1: further bubble events leave it unchanged, with no wrap.
- No combinational path from any input to any output. All outputs come directly from flops.
- Register specifiers pass through unmodified. Destination selection (rt vs rd) is done downstream using ex_reg_dst.

## Timing
- Latency: 1 cycle. Inputs sampled at edge N appear on ex_* outputs after edge N.
- Stall asserted for k consecutive edges holds outputs for k cycles. The load resumes on the first edge with stall=0.
- flush and stall asserted together at one edge: the flush wins. Outputs become a bubble and the held instruction is discarded. The upstream IF/ID stage keeps its own stalled instruction.
- reset asserted mid-stall or mid-flush: the reset wins that edge. On the first edge after reset deasserts, normal priority applies.
- ex_* outputs are stable for the whole cycle following the edge, so the ALU and alu_control see a full cycle of settled operands.

## Test plan
- Reset, then load:
  - Stimulus: reset high for 2 edges, then drive id_valid=1, id_rs_data=0x0000_0005, id_rt_data=0x0000_0003, id_alu_op=10, id_funct=0x20, id_reg_write=1.
  - Response: all outputs 0 during reset. One edge later ex_rs_data=5, ex_rt_data=3, ex_funct=0x20, ex_reg_write=1, ex_valid=1.
- Stall hold:
  - Stimulus: after loading id_imm_ext=0xFFFF_FFFC, assert stall for 3 edges while changing id_imm_ext to 0x1234.
  - Response: ex_imm_ext stays 0xFFFF_FFFC for 3 cycles and becomes 0x1234 on the edge after stall drops. bubble_count is unchanged.
- Flush:
  - Stimulus: load an lw (mem_read=1, reg_write=1, mem_to_reg=1), then assert flush for 1 edge.
  - Response: all ex_* outputs = 0 and bubble_count increments by 1.
- Flush with stall:
  - Stimulus: assert stall=1 and flush=1 on the same edge.
  - Response: outputs become a bubble, not a hold. bubble_count increments.
- Invalid decode slot:
  - Stimulus: id_valid=0, id_reg_write=1, id_mem_write=1, id_rs_data=0xAAAA_AAAA.
  - Response: ex_valid=0, ex_reg_write=0, ex_mem_write=0, ex_rs_data=0xAAAA_AAAA, bubble_count +1.
- Counter saturation and reset mid-flush:
  - Stimulus: with CNT_W=4, apply 20 consecutive flushes.
  - Response: bubble_count stops at 15. Asserting reset together with flush gives bubble_count=0.

Source files
------------

// File: rtl/id_ex_reg.sv
// ID/EX pipeline register: captures decode control/data each edge with hazard stall,
// flush bubble insertion, invalid-slot gating and a saturating bubble counter.
module id_ex_reg #(
  parameter int W     = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             flush,
  input  logic             id_valid,
  input  logic             id_reg_write,
  input  logic             id_mem_read,
  input  logic             id_mem_write,
  input  logic             id_mem_to_reg,
  input  logic             id_alu_src,
  input  logic             id_reg_dst,
  input  logic             id_branch,
  input  logic [1:0]       id_alu_op,
  input  logic [W-1:0]     id_pc_plus4,
  input  logic [W-1:0]     id_rs_data,
  input  logic [W-1:0]     id_rt_data,
  input  logic [W-1:0]     id_imm_ext,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic [4:0]       id_rd,
  input  logic [5:0]       id_funct,
  output logic             ex_valid,
  output logic             ex_reg_write,
  output logic             ex_mem_read,
  output logic             ex_mem_write,
  output logic             ex_mem_to_reg,
  output logic             ex_alu_src,
  output logic             ex_reg_dst,
  output logic             ex_branch,
  output logic [1:0]       ex_alu_op,
  output logic [W-1:0]     ex_pc_plus4,
  output logic [W-1:0]     ex_rs_data,
  output logic [W-1:0]     ex_rt_data,
  output logic [W-1:0]     ex_imm_ext,
  output logic [4:0]       ex_rs,
  output logic [4:0]       ex_rt,
  output logic [4:0]       ex_rd,
  output logic [5:0]       ex_funct,
  output logic [CNT_W-1:0] bubble_count
);

  // Valid semantics: ex_valid qualifies the slot; the side-effecting controls
  // (reg_write, mem_read, mem_write, branch) are only ever 1 alongside ex_valid.
  logic             r_valid;
  logic             r_reg_write;
  logic             r_mem_read;
  logic             r_mem_write;
  logic             r_mem_to_reg;
  logic             r_alu_src;
  logic             r_reg_dst;
  logic             r_branch;
  logic [1:0]       r_alu_op;
  logic [W-1:0]     r_pc_plus4;
  logic [W-1:0]     r_rs_data;
  logic [W-1:0]     r_rt_data;
  logic [W-1:0]     r_imm_ext;
  logic [4:0]       r_rs;
  logic [4:0]       r_rt;
  logic [4:0]       r_rd;
  logic [5:0]       r_funct;
  logic [CNT_W-1:0] r_bubble_count;

  logic w_bubble;
  logic w_cnt_full;

  // A bubble is either a flush or a load of an empty decode slot; a stall alone is not.
  assign w_bubble   = flush | (~stall & ~id_valid);
  assign w_cnt_full = &r_bubble_count;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid        <= 1'b0;
      r_reg_write    <= 1'b0;
      r_mem_read     <= 1'b0;
      r_mem_write    <= 1'b0;
      r_mem_to_reg   <= 1'b0;
      r_alu_src      <= 1'b0;
      r_reg_dst      <= 1'b0;
      r_branch       <= 1'b0;
      r_alu_op       <= 2'b00;
      r_pc_plus4     <= '0;
      r_rs_data      <= '0;
      r_rt_data      <= '0;
      r_imm_ext      <= '0;
      r_rs           <= '0;
      r_rt           <= '0;
      r_rd           <= '0;
      r_funct        <= '0;
      r_bubble_count <= '0;
    end else begin
      if (flush) begin
        r_valid      <= 1'b0;
        r_reg_write  <= 1'b0;
        r_mem_read   <= 1'b0;
        r_mem_write  <= 1'b0;
        r_mem_to_reg <= 1'b0;
        r_alu_src    <= 1'b0;
        r_reg_dst    <= 1'b0;
        r_branch     <= 1'b0;
        r_alu_op     <= 2'b00;
        r_pc_plus4   <= '0;
        r_rs_data    <= '0;
        r_rt_data    <= '0;
        r_imm_ext    <= '0;
        r_rs         <= '0;
        r_rt         <= '0;
        r_rd         <= '0;
        r_funct      <= '0;
      end else if (!stall) begin
        r_valid      <= id_valid;
        r_reg_write  <= id_reg_write & id_valid;
        r_mem_read   <= id_mem_read  & id_valid;
        r_mem_write  <= id_mem_write & id_valid;
        r_branch     <= id_branch    & id_valid;
        r_mem_to_reg <= id_mem_to_reg;
        r_alu_src    <= id_alu_src;
        r_reg_dst    <= id_reg_dst;
        r_alu_op     <= id_alu_op;
        r_pc_plus4   <= id_pc_plus4;
        r_rs_data    <= id_rs_data;
        r_rt_data    <= id_rt_data;
        r_imm_ext    <= id_imm_ext;
        r_rs         <= id_rs;
        r_rt         <= id_rt;
        r_rd         <= id_rd;
        r_funct      <= id_funct;
      end
      if (w_bubble && !w_cnt_full) begin
        r_bubble_count <= r_bubble_count + CNT_W'(1);
      end
    end
  end

  assign ex_valid      = r_valid;
  assign ex_reg_write  = r_reg_write;
  assign ex_mem_read   = r_mem_read;
  assign ex_mem_write  = r_mem_write;
  assign ex_mem_to_reg = r_mem_to_reg;
  assign ex_alu_src    = r_alu_src;
  assign ex_reg_dst    = r_reg_dst;
  assign ex_branch     = r_branch;
  assign ex_alu_op     = r_alu_op;
  assign ex_pc_plus4   = r_pc_plus4;
  assign ex_rs_data    = r_rs_data;
  assign ex_rt_data    = r_rt_data;
  assign ex_imm_ext    = r_imm_ext;
  assign ex_rs         = r_rs;
  assign ex_rt         = r_rt;
  assign ex_rd         = r_rd;
  assign ex_funct      = r_funct;
  assign bubble_count  = r_bubble_count;

endmodule
